pid_coincidence_trigger: RTL and testbench

Consumes the per-channel captured hit bits produced by the asynchronous input-capture stages (one per detector channel) and forms the PID coincidence trigger. Each channel is synchronised and converted to a single-cycle new-hit pulse. A coincidence window opens on the first hit and accumulates a channel pattern. When the number of hit channels reaches a programmable threshold, the block issues a fixed-width trigger followed by a deadtime. It also keeps accepted-trigger and lost-hit counters.

---
 rtl/pid_trig_pkg.sv | 34 +++
 rtl/pid_coincidence_trigger_hit_sync_edge.sv | 35 +++
 rtl/pid_coincidence_trigger.sv | 173 +++++++++++++++++
 tb/tb_pid_coincidence_trigger.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pid_trig_pkg.sv
// Shared types and helpers for the PID coincidence trigger.
// Channel counts up to MAX_CH are supported by the popcount helper.
package pid_trig_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WINDOW = 2'd1,
        ST_FIRE   = 2'd2,
        ST_DEAD   = 2'd3
    } state_t;

    localparam int unsigned MAX_CH    = 64;
    localparam int unsigned POP_W     = $clog2(MAX_CH + 1);
    localparam int unsigned N_CH_DEF  = 8;
    localparam int unsigned CNT_W_DEF = 16;
    localparam int unsigned THR_W_DEF = $clog2(N_CH_DEF + 1);

    function automatic logic [POP_W-1:0] popcount(input logic [MAX_CH-1:0] v);
        logic [POP_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < int'(MAX_CH); i++) begin
            cnt = cnt + POP_W'(v[i]);
        end
        return cnt;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pid_coincidence_trigger_hit_sync_edge.sv
// One detector channel: 3-flop synchroniser plus rising-edge detector.
// An edge is only reported once the channel has been seen low after reset.
module hit_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_hit,
    output logic o_hit_new_c
);

    logic r_sync1;
    logic r_sync2;
    logic r_sync3;
    logic r_vld;
    logic r_arm;

    // r_vld marks that r_sync1 holds a real post-reset sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
            r_vld   <= 1'b0;
            r_arm   <= 1'b0;
        end else begin
            r_sync1 <= i_hit;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_vld   <= 1'b1;
            r_arm   <= r_arm | (r_vld & ~r_sync1);
        end
    end

    assign o_hit_new_c = r_sync2 & ~r_sync3 & r_arm;

endmodule

// File: rtl/pid_coincidence_trigger.sv
// PID coincidence trigger: per-channel edge detect, coincidence window,
// fixed-width trigger with deadtime, and saturating trigger/lost counters.
module pid_coincidence_trigger
    import pid_trig_pkg::*;
#(
    parameter int unsigned N_CH       = N_CH_DEF,
    parameter int unsigned WINDOW     = 4,
    parameter int unsigned TRIG_WIDTH = 2,
    parameter int unsigned DEADTIME   = 16,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_CH-1:0]             hit_in,
    input  logic                        enable,
    input  logic [$clog2(N_CH+1)-1:0]   min_hits,
    input  logic                        clear_counts,
    output logic                        trig_out,
    output logic [N_CH-1:0]             trig_mask,
    output logic                        busy,
    output logic [CNT_W-1:0]            trig_count,
    output logic [CNT_W-1:0]            lost_count
);

    localparam int unsigned CNT_MAX = max3(WINDOW, TRIG_WIDTH, DEADTIME);
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SAT_V = '1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_nxt;
    logic [N_CH-1:0]     r_pattern;
    logic [N_CH-1:0]     w_pattern_nxt;
    logic [N_CH-1:0]     w_hit_new;
    logic [N_CH-1:0]     w_cand;
    logic [POP_W-1:0]    w_thr;
    logic                w_any_new;
    logic                w_accept;
    logic                w_met;
    logic                w_fire;
    logic                w_lost;

    logic                r_trig_out;
    logic                r_busy;
    logic [N_CH-1:0]     r_trig_mask;
    logic [CNT_W-1:0]    r_trig_count;
    logic [CNT_W-1:0]    r_lost_count;

    for (genvar g = 0; g < int'(N_CH); g++) begin : g_ch
        hit_sync_edge u_sync (
            .clk         (clk),
            .rst         (rst),
            .i_hit       (hit_in[g]),
            .o_hit_new_c (w_hit_new[g])
        );
    end

    assign w_any_new = |w_hit_new;
    assign w_accept  = enable & ((r_state == ST_IDLE) | (r_state == ST_WINDOW));
    assign w_cand    = r_pattern | (w_hit_new & {N_CH{w_accept}});
    assign w_thr     = (min_hits == '0) ? POP_W'(1) : POP_W'(min_hits);
    assign w_met     = popcount(MAX_CH'(w_cand)) >= w_thr;
    assign w_lost    = enable & w_any_new & ((r_state == ST_FIRE) | (r_state == ST_DEAD));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_pattern <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pattern <= w_pattern_nxt;
        end
    end

    // r_cnt is shared: window age, trigger width, then deadtime
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pattern_nxt = r_pattern;
        w_fire        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable && w_any_new) begin
                    if (w_met) begin
                        w_fire = 1'b1;
                    end else if (WINDOW > 1) begin
                        w_state_nxt   = ST_WINDOW;
                        w_pattern_nxt = w_hit_new;
                        w_cnt_nxt     = CW'(1);
                    end
                end
            end
            ST_WINDOW: begin
                if (!enable) begin
                    w_state_nxt   = ST_IDLE;
                    w_pattern_nxt = '0;
                end else if (w_met) begin
                    w_fire = 1'b1;
                end else if (r_cnt == CW'(WINDOW - 1)) begin
                    w_state_nxt   = ST_IDLE;
                    w_pattern_nxt = '0;
                end else begin
                    w_pattern_nxt = w_cand;
                    w_cnt_nxt     = r_cnt + CW'(1);
                end
            end
            ST_FIRE: begin
                if (r_cnt == CW'(TRIG_WIDTH)) begin
                    w_state_nxt = (DEADTIME == 0) ? ST_IDLE : ST_DEAD;
                    w_cnt_nxt   = CW'(1);
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_DEAD: begin
                if (r_cnt == CW'(DEADTIME)) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_cnt_nxt     = '0;
                w_pattern_nxt = '0;
            end
        endcase
        if (w_fire) begin
            w_state_nxt   = ST_FIRE;
            w_cnt_nxt     = CW'(1);
            w_pattern_nxt = '0;
        end
    end

    // Outputs are registered from the next state so trig_out aligns with FIRE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_trig_out   <= 1'b0;
            r_busy       <= 1'b0;
            r_trig_mask  <= '0;
            r_trig_count <= '0;
            r_lost_count <= '0;
        end else begin
            r_trig_out <= (w_state_nxt == ST_FIRE);
            r_busy     <= (w_state_nxt == ST_FIRE) | (w_state_nxt == ST_DEAD);
            if (w_fire) begin
                r_trig_mask <= w_cand;
            end
            if (clear_counts) begin
                r_trig_count <= '0;
                r_lost_count <= '0;
            end else begin
                if (w_fire && (r_trig_count != SAT_V)) begin
                    r_trig_count <= r_trig_count + CNT_W'(1);
                end
                if (w_lost && (r_lost_count != SAT_V)) begin
                    r_lost_count <= r_lost_count + CNT_W'(1);
                end
            end
        end
    end

    assign trig_out   = r_trig_out;
    assign busy       = r_busy;
    assign trig_mask  = r_trig_mask;
    assign trig_count = r_trig_count;
    assign lost_count = r_lost_count;

endmodule

// File: tb/tb_pid_coincidence_trigger.sv
// Self-checking bench for pid_coincidence_trigger: directed scenarios plus a
// randomized run against a behavioural model; a 3-bit-counter copy exercises saturation.
module tb_pid_coincidence_trigger;

    localparam int unsigned N_CH       = 8;
    localparam int unsigned WINDOW     = 4;
    localparam int unsigned TRIG_WIDTH = 2;
    localparam int unsigned DEADTIME   = 16;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned SAT_W      = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N_CH-1:0]   hit_in = '0;
    logic              enable = 1'b0;
    logic [3:0]        min_hits = 4'd0;
    logic              clear_counts = 1'b0;

    logic              trig_out, busy;
    logic [N_CH-1:0]   trig_mask;
    logic [CNT_W-1:0]  trig_count, lost_count;
    logic              s_trig_out, s_busy;
    logic [N_CH-1:0]   s_trig_mask;
    logic [SAT_W-1:0]  s_trig_count, s_lost_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pid_coincidence_trigger #(.N_CH(N_CH), .WINDOW(WINDOW), .TRIG_WIDTH(TRIG_WIDTH),
                              .DEADTIME(DEADTIME), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst(rst), .hit_in(hit_in), .enable(enable), .min_hits(min_hits),
        .clear_counts(clear_counts), .trig_out(trig_out), .trig_mask(trig_mask),
        .busy(busy), .trig_count(trig_count), .lost_count(lost_count));

    pid_coincidence_trigger #(.N_CH(N_CH), .WINDOW(WINDOW), .TRIG_WIDTH(TRIG_WIDTH),
                              .DEADTIME(DEADTIME), .CNT_W(SAT_W)) u_dut_sat (
        .clk(clk), .rst(rst), .hit_in(hit_in), .enable(enable), .min_hits(min_hits),
        .clear_counts(clear_counts), .trig_out(s_trig_out), .trig_mask(s_trig_mask),
        .busy(s_busy), .trig_count(s_trig_count), .lost_count(s_lost_count));

    // Reference model: remaining-time counters rather than a state machine.
    // A rising edge needs a low sample after reset, so pre-reset history reads as 1.
    logic [N_CH-1:0] m_s0 = '1, m_s1 = '1, m_s2 = '1;
    logic [N_CH-1:0] m_pattern = '0, m_mask = '0;
    int  m_fire_left = 0, m_dead_left = 0, m_win_left = 0;
    bit  m_win_open = 1'b0;
    int  m_trig_n = 0, m_lost_n = 0;

    always @(posedge clk or posedge rst) begin : ref_model
        logic [N_CH-1:0] hn, cand;
        int thr;
        bit fire_ev, lost_ev;
        if (rst) begin
            m_s0 = '1; m_s1 = '1; m_s2 = '1;
            m_pattern = '0; m_mask = '0;
            m_fire_left = 0; m_dead_left = 0; m_win_left = 0; m_win_open = 1'b0;
            m_trig_n = 0; m_lost_n = 0;
        end else begin
            hn = m_s1 & ~m_s2;
            m_s2 = m_s1; m_s1 = m_s0; m_s0 = hit_in;
            fire_ev = 1'b0; lost_ev = 1'b0;
            thr = (min_hits == 4'd0) ? 1 : int'(min_hits);
            if (m_fire_left > 0 || m_dead_left > 0) begin
                lost_ev = enable && (hn != '0);
                if (m_fire_left > 0) begin
                    m_fire_left--;
                    if (m_fire_left == 0) m_dead_left = int'(DEADTIME);
                end else begin
                    m_dead_left--;
                end
            end else begin
                cand = m_pattern | (enable ? hn : '0);
                if (m_win_open && !enable) begin
                    m_win_open = 1'b0; m_pattern = '0;
                end else if (enable && (m_win_open || hn != '0) && $countones(cand) >= thr) begin
                    fire_ev = 1'b1; m_mask = cand; m_fire_left = int'(TRIG_WIDTH);
                    m_win_open = 1'b0; m_pattern = '0;
                end else if (m_win_open) begin
                    m_pattern = cand;
                    m_win_left--;
                    if (m_win_left == 0) begin
                        m_win_open = 1'b0; m_pattern = '0;
                    end
                end else if (enable && hn != '0 && WINDOW > 1) begin
                    m_win_open = 1'b1; m_pattern = hn; m_win_left = int'(WINDOW) - 1;
                end
            end
            if (clear_counts) begin
                m_trig_n = 0; m_lost_n = 0;
            end else begin
                m_trig_n += int'(fire_ev);
                m_lost_n += int'(lost_ev);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; hit_in = '0; min_hits = 4'd0; clear_counts = 1'b0;
        step(3);
        checks++;
        if ({trig_out, busy, trig_mask, trig_count, lost_count} !== '0) begin
            errors++; $display("FAIL reset_main got %b exp 0", {trig_out, busy, trig_mask, trig_count, lost_count});
        end
        checks++;
        if ({s_trig_out, s_busy, s_trig_mask, s_trig_count, s_lost_count} !== '0) begin
            errors++; $display("FAIL reset_sat got %b exp 0", {s_trig_out, s_busy, s_trig_mask, s_trig_count, s_lost_count});
        end
        rst = 1'b0;
        step(3);
        checks++;
        if ({trig_out, busy, trig_count} !== '0) begin
            errors++; $display("FAIL reset_release got %b exp 0", {trig_out, busy, trig_count});
        end
    endtask

    task automatic test_single();
        enable = 1'b1; min_hits = 4'd2;
        step(2);
        hit_in = 8'h09;
        step(1);
        hit_in = '0;
        checks++;
        if (trig_out !== 1'b0) begin errors++; $display("FAIL single_e0 trig got %b exp 0", trig_out); end
        step(1);
        checks++;
        if (trig_out !== 1'b0) begin errors++; $display("FAIL single_e1 trig got %b exp 0", trig_out); end
        step(1);
        checks++;
        if ({trig_out, busy} !== 2'b11) begin errors++; $display("FAIL single_e2 trig/busy got %b exp 11", {trig_out, busy}); end
        step(1);
        checks++;
        if (trig_out !== 1'b1) begin errors++; $display("FAIL single_e3 trig got %b exp 1", trig_out); end
        checks++;
        if (trig_mask !== 8'h09) begin errors++; $display("FAIL single_mask got %h exp 09", trig_mask); end
        checks++;
        if (trig_count !== 16'd1) begin errors++; $display("FAIL single_count got %0d exp 1", trig_count); end
        step(1);
        checks++;
        if ({trig_out, busy} !== 2'b01) begin errors++; $display("FAIL single_dead got %b exp 01", {trig_out, busy}); end
        step(15);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL single_dead_end busy got %b exp 1", busy); end
        step(1);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL single_idle busy got %b exp 0", busy); end
    endtask

    task automatic test_window_edge();
        step(5);
        min_hits = 4'd2;
        hit_in = 8'h02; step(1); hit_in = '0;
        step(2);
        hit_in = 8'h20; step(1); hit_in = '0;
        step(1);
        checks++;
        if (trig_out !== 1'b0) begin errors++; $display("FAIL win_in_early got %b exp 0", trig_out); end
        step(1);
        checks++;
        if ({trig_out, trig_mask} !== {1'b1, 8'h22}) begin
            errors++; $display("FAIL win_in trig/mask got %b/%h exp 1/22", trig_out, trig_mask);
        end
        step(25);
        hit_in = 8'h02; step(1); hit_in = '0;
        step(3);
        hit_in = 8'h20; step(1); hit_in = '0;
        step(1);
        checks++;
        if ({trig_out, busy} !== 2'b00) begin errors++; $display("FAIL win_out got %b exp 00", {trig_out, busy}); end
        hit_in = 8'h40; step(1); hit_in = '0;
        checks++;
        if (trig_out !== 1'b0) begin errors++; $display("FAIL win_reopen_early got %b exp 0", trig_out); end
        step(2);
        checks++;
        if ({trig_out, trig_mask} !== {1'b1, 8'h60}) begin
            errors++; $display("FAIL win_reopen trig/mask got %b/%h exp 1/60", trig_out, trig_mask);
        end
        checks++;
        if (trig_count !== 16'd3) begin errors++; $display("FAIL win_count got %0d exp 3", trig_count); end
    endtask

    task automatic test_deadtime();
        bit saw;
        step(25);
        clear_counts = 1'b1; step(1); clear_counts = 1'b0;
        checks++;
        if ({trig_count, lost_count} !== 32'd0) begin
            errors++; $display("FAIL dead_clear got %0d/%0d exp 0/0", trig_count, lost_count);
        end
        hit_in = 8'h03; step(1); hit_in = '0;
        step(4);
        checks++;
        if ({trig_out, busy} !== 2'b01) begin errors++; $display("FAIL dead_state got %b exp 01", {trig_out, busy}); end
        hit_in = 8'h04; step(1); hit_in = '0;
        step(2);
        hit_in = 8'h04; step(1); hit_in = '0;
        step(2);
        hit_in = 8'h04; step(1); hit_in = '0;
        saw = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (trig_out) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0) begin errors++; $display("FAIL dead_retrig got %b exp 0", saw); end
        checks++;
        if (lost_count !== 16'd3) begin errors++; $display("FAIL dead_lost got %0d exp 3", lost_count); end
        hit_in = 8'h10; step(1); hit_in = '0;
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (trig_out) saw = 1'b1;
        end
        checks++;
        if ({saw, trig_count} !== {1'b0, 16'd1}) begin
            errors++; $display("FAIL dead_spurious_window trig/count got %b/%0d exp 0/1", saw, trig_count);
        end
    endtask

    task automatic test_threshold();
        bit saw;
        step(25);
        min_hits = 4'd0;
        hit_in = 8'h80; step(1); hit_in = '0;
        step(2);
        checks++;
        if ({trig_out, trig_mask} !== {1'b1, 8'h80}) begin
            errors++; $display("FAIL thr_zero trig/mask got %b/%h exp 1/80", trig_out, trig_mask);
        end
        step(25);
        min_hits = 4'd9;
        hit_in = 8'hFF; step(1); hit_in = '0;
        saw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (trig_out) saw = 1'b1;
        end
        min_hits = 4'd1;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (trig_out || busy) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0) begin errors++; $display("FAIL thr_nine fired got %b exp 0", saw); end
        checks++;
        if (trig_count !== 16'd2) begin errors++; $display("FAIL thr_count got %0d exp 2", trig_count); end
    endtask

    task automatic test_control();
        bit saw;
        step(25);
        min_hits = 4'd2;
        hit_in = 8'h01; step(1); hit_in = '0;
        step(2);
        enable = 1'b0; step(1); enable = 1'b1;
        hit_in = 8'h02; step(1); hit_in = '0;
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (trig_out) saw = 1'b1;
        end
        checks++;
        if ({saw, trig_count} !== {1'b0, 16'd2}) begin
            errors++; $display("FAIL ctl_abort trig/count got %b/%0d exp 0/2", saw, trig_count);
        end
        step(5);
        hit_in = 8'h03; step(1); hit_in = '0;
        step(1);
        clear_counts = 1'b1; step(1); clear_counts = 1'b0;
        checks++;
        if ({trig_out, trig_mask, trig_count} !== {1'b1, 8'h03, 16'd0}) begin
            errors++; $display("FAIL ctl_clear_fire got %b/%h/%0d exp 1/03/0", trig_out, trig_mask, trig_count);
        end
    endtask

    task automatic test_saturation();
        step(25);
        clear_counts = 1'b1; step(1); clear_counts = 1'b0;
        min_hits = 4'd1;
        for (int k = 0; k < 9; k++) begin
            hit_in = 8'h01; step(1); hit_in = '0;
            step(4);
            hit_in = 8'h02; step(1); hit_in = '0;
            step(25);
        end
        checks++;
        if ({trig_count, lost_count} !== {16'd9, 16'd9}) begin
            errors++; $display("FAIL sat_main got %0d/%0d exp 9/9", trig_count, lost_count);
        end
        checks++;
        if ({s_trig_count, s_lost_count} !== {3'h7, 3'h7}) begin
            errors++; $display("FAIL sat_hold got %0d/%0d exp 7/7", s_trig_count, s_lost_count);
        end
    endtask

    task automatic test_async_reset();
        bit saw;
        step(5);
        min_hits = 4'd1;
        hit_in = 8'h04; step(1); hit_in = '0;
        step(2);
        checks++;
        if (trig_out !== 1'b1) begin errors++; $display("FAIL arst_pre trig got %b exp 1", trig_out); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({trig_out, busy, trig_mask, trig_count, lost_count} !== '0) begin
            errors++; $display("FAIL arst_imm got %b exp 0", {trig_out, busy, trig_mask, trig_count, lost_count});
        end
        hit_in = 8'h10;
        step(3);
        rst = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (trig_out || busy) saw = 1'b1;
        end
        hit_in = '0;
        step(4);
        checks++;
        if (saw !== 1'b0) begin errors++; $display("FAIL arst_held_level got %b exp 0", saw); end
        hit_in = 8'h10; step(1); hit_in = '0;
        step(2);
        checks++;
        if ({trig_out, trig_mask} !== {1'b1, 8'h10}) begin
            errors++; $display("FAIL arst_rearm got %b/%h exp 1/10", trig_out, trig_mask);
        end
        step(25);
    endtask

    task automatic test_random();
        logic [CNT_W-1:0] e_tc, e_lc;
        logic [SAT_W-1:0] e_stc, e_slc;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            e_tc  = (m_trig_n > 65535) ? 16'hFFFF : CNT_W'(m_trig_n);
            e_lc  = (m_lost_n > 65535) ? 16'hFFFF : CNT_W'(m_lost_n);
            e_stc = (m_trig_n > 7) ? 3'h7 : SAT_W'(m_trig_n);
            e_slc = (m_lost_n > 7) ? 3'h7 : SAT_W'(m_lost_n);
            checks++;
            if (trig_out !== (m_fire_left > 0)) begin
                errors++; $display("FAIL rand_trig cyc %0d got %b exp %b", cyc, trig_out, (m_fire_left > 0));
            end
            checks++;
            if (busy !== (m_fire_left > 0 || m_dead_left > 0)) begin
                errors++; $display("FAIL rand_busy cyc %0d got %b exp %b", cyc, busy, (m_fire_left > 0 || m_dead_left > 0));
            end
            checks++;
            if (trig_mask !== m_mask) begin
                errors++; $display("FAIL rand_mask cyc %0d got %h exp %h", cyc, trig_mask, m_mask);
            end
            checks++;
            if ({trig_count, lost_count} !== {e_tc, e_lc}) begin
                errors++; $display("FAIL rand_counts cyc %0d got %0d/%0d exp %0d/%0d", cyc, trig_count, lost_count, e_tc, e_lc);
            end
            checks++;
            if ({s_trig_count, s_lost_count} !== {e_stc, e_slc}) begin
                errors++; $display("FAIL rand_sat cyc %0d got %0d/%0d exp %0d/%0d", cyc, s_trig_count, s_lost_count, e_stc, e_slc);
            end
            for (int b = 0; b < int'(N_CH); b++) begin
                hit_in[b] = ($urandom_range(0, 9) == 0);
            end
            enable       = ($urandom_range(0, 19) != 0);
            clear_counts = ($urandom_range(0, 299) == 0);
            if (cyc % 200 == 0) min_hits = 4'($urandom_range(0, 9));
        end
        hit_in = '0; enable = 1'b1; clear_counts = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_window_edge();
        test_deadtime();
        test_threshold();
        test_control();
        test_saturation();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
